// File: rtl/rwt_tag_extract_demux.sv
// Splits a merged data/tag stream into a data stream and an index-stamped tag stream.
// Optional RWT_TAG_EXTRACT_DROP_EN: drop tags on tag-buffer overflow instead of stalling.
module rwt_tag_extract_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         full_d_o
);
  logic         mv_q, mv_d;
  logic         sv_q, sv_d;
  logic [W-1:0] m_q, m_d;
  logic [W-1:0] s_q, s_d;
  logic         pop;

  assign pop      = mv_q & ready_i;
  assign valid_o  = mv_q;
  assign data_o   = m_q;
  assign full_o   = sv_q;
  assign full_d_o = sv_d;

  always_comb begin
    mv_d = mv_q;
    sv_d = sv_q;
    m_d  = m_q;
    s_d  = s_q;
    if (pop) begin
      if (sv_q) begin
        m_d  = s_q;
        sv_d = push_i;
        if (push_i) s_d = data_i;
      end else begin
        mv_d = push_i;
        if (push_i) m_d = data_i;
      end
    end else if (push_i) begin
      if (!mv_q) begin
        mv_d = 1'b1;
        m_d  = data_i;
      end else begin
        sv_d = 1'b1;
        s_d  = data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      mv_q <= 1'b0;
      sv_q <= 1'b0;
    end else begin
      mv_q <= mv_d;
      sv_q <= sv_d;
    end
    m_q <= m_d;
    s_q <= s_d;
  end
endmodule

module rwt_tag_extract_demux #(
  parameter int CNT_WIDTH     = 32,
  parameter bit RESET_ON_LAST = 1'b1
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [63:0]          s_data,
  input  logic                 s_tag_valid,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [63:0]          m_data,
  output logic                 m_last,
  output logic                 t_valid,
  input  logic                 t_ready,
  output logic [6:0]           t_type,
  output logic [55:0]          t_data,
  output logic [CNT_WIDTH-1:0] t_index,
  output logic [15:0]          drop_count
);
  localparam int TW = 63 + CNT_WIDTH;

  logic                 rdy_q, rdy_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 acc, d_hit, t_hit;
  logic                 d_push, t_push;
  logic                 d_full, d_full_d;
  logic                 t_full, t_full_d;
  logic [64:0]          d_out;
  logic [TW-1:0]        t_out;

  assign s_ready = rdy_q;
  assign acc     = s_valid & rdy_q;
  assign d_hit   = acc & ~s_tag_valid;
  assign t_hit   = acc & s_tag_valid;
  // A full skid is never overwritten; without the drop feature s_ready guarantees it.
  assign d_push  = d_hit & ~d_full;
  assign t_push  = t_hit & ~t_full;

  always_comb begin
    cnt_d = cnt_q;
    if (d_hit) begin
      if (RESET_ON_LAST && s_last) cnt_d = '0;
      else cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

`ifdef RWT_TAG_EXTRACT_DROP_EN
  logic [15:0] drop_q;
  logic        t_drop;

  assign t_drop     = t_hit & t_full;
  assign rdy_d      = ~d_full_d;
  assign drop_count = drop_q;

  always_ff @(posedge clk) begin
    if (areset) drop_q <= '0;
    else if (t_drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  end
`else
  assign rdy_d      = ~d_full_d & ~t_full_d;
  assign drop_count = '0;
`endif

  always_ff @(posedge clk) begin
    if (areset) begin
      rdy_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      rdy_q <= rdy_d;
      cnt_q <= cnt_d;
    end
  end

  rwt_tag_extract_skid #(.W(65)) u_dbuf (
    .clk      (clk),
    .areset   (areset),
    .push_i   (d_push),
    .data_i   ({s_last, s_data}),
    .ready_i  (m_ready),
    .valid_o  (m_valid),
    .data_o   (d_out),
    .full_o   (d_full),
    .full_d_o (d_full_d)
  );

  rwt_tag_extract_skid #(.W(TW)) u_tbuf (
    .clk      (clk),
    .areset   (areset),
    .push_i   (t_push),
    .data_i   ({s_data[62:56], s_data[55:0], cnt_q}),
    .ready_i  (t_ready),
    .valid_o  (t_valid),
    .data_o   (t_out),
    .full_o   (t_full),
    .full_d_o (t_full_d)
  );

  assign {m_last, m_data}         = d_out;
  assign {t_type, t_data, t_index} = t_out;
endmodule
